// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: the NOP used to fill
// empty IF/ID slots, the fetch FSM state encoding and the default reset PC.
package fetch_stage_pkg;

    // addi x0, x0, 0 -- the canonical RISC-V no-op
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // First fetch address when the instantiating design does not override it
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // FETCH: request on the bus; WAIT: one request outstanding;
    // HOLD: response parked in the skid buffer while decode is stalled
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction word and its address while
// the IF/ID register is occupied by a stalled instruction.
module fetch_skid_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_unload,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [DATA_WIDTH-1:0] o_addr,
    output logic                  o_full
);

    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_addr;

    // Occupancy flag: clear (redirect) wins over load, load over unload
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    // Payload capture
    // NOTE: the payload is deliberately not reset; r_full alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_data <= i_data;
            r_addr <= i_addr;
        end
    end

    assign o_data = r_data;
    assign o_addr = r_addr;
    assign o_full = r_full;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues at most one imem request at a time, feeds
// the IF/ID register, absorbs decode stalls with a skid buffer and handles
// taken-branch redirects, dropping the stale response where needed.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  stall_D,
    input  logic                  branch_taken_D,
    input  logic [DATA_WIDTH-1:0] branch_target_D,
    output logic [DATA_WIDTH-1:0] instr_D,
    output logic [DATA_WIDTH-1:0] pc_D,
    output logic                  valid_D
);

    localparam logic [DATA_WIDTH-1:0] NOP      = DATA_WIDTH'(NOP_INSTR);
    localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MK = ~DATA_WIDTH'(3);

    fetch_state_e          r_state;
    logic [DATA_WIDTH-1:0] r_pc_f;
    logic [DATA_WIDTH-1:0] r_fetch_addr;
    logic                  r_drop;
    logic                  r_req_valid;
    logic [DATA_WIDTH-1:0] r_instr_d;
    logic [DATA_WIDTH-1:0] r_pc_d;
    logic                  r_valid_d;

    logic                  w_redirect;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_target;
    logic                  w_skid_load;
    logic                  w_skid_unload;
    logic                  w_skid_clear;
    logic [DATA_WIDTH-1:0] w_skid_data;
    logic [DATA_WIDTH-1:0] w_skid_addr;
    logic                  w_skid_full;

    // A redirect is only honoured when decode actually holds the branch and is advancing
    assign w_redirect = branch_taken_D & r_valid_d & ~stall_D;
    // The request register is only ever high in FETCH, so this is the handshake
    assign w_accept   = r_req_valid & imem_req_ready;
    assign w_target   = branch_target_D & ALIGN_MK;

    // Skid buffer strobes derived from the current state and this cycle's events
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_skid_load   = 1'b0;
        w_skid_unload = 1'b0;
        w_skid_clear  = w_redirect;
        if (r_state == WAIT && imem_rsp_valid && !r_drop && !w_redirect
            && r_valid_d && stall_D) begin
            w_skid_load = 1'b1;
        end
        if (r_state == HOLD && !stall_D && !w_redirect && w_skid_full) begin
            w_skid_unload = 1'b1;
        end
    end

    fetch_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (w_skid_clear),
        .i_data   (imem_rsp_data),
        .i_addr   (r_fetch_addr),
        .o_data   (w_skid_data),
        .o_addr   (w_skid_addr),
        .o_full   (w_skid_full)
    );

    // Fetch FSM with registered request and IF/ID outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= FETCH;
            r_pc_f       <= RESET_PC;
            r_fetch_addr <= RESET_PC;
            r_drop       <= 1'b0;
            r_req_valid  <= 1'b0;
            r_instr_d    <= NOP;
            r_pc_d       <= '0;
            r_valid_d    <= 1'b0;
        end else begin
            // IF/ID default: bubble when decode advances, hold when stalled.
            // A redirect always has stall_D low, so this also performs the flush.
            // NOTE: a later non-blocking assignment in this block overrides this default for the same edge.
            if (!stall_D) begin
                r_valid_d <= 1'b0;
                r_instr_d <= NOP;
            end

            unique case (r_state)
                FETCH: begin
                    if (w_redirect) begin
                        // An accepted-but-stale request must have its response dropped
                        r_pc_f      <= w_target;
                        r_drop      <= w_accept;
                        r_state     <= w_accept ? WAIT : FETCH;
                        r_req_valid <= ~w_accept;
                    end else if (w_accept) begin
                        r_fetch_addr <= r_pc_f;
                        r_pc_f       <= r_pc_f + PC_STEP;
                        r_state      <= WAIT;
                        r_req_valid  <= 1'b0;
                    end else begin
                        r_req_valid  <= 1'b1;
                    end
                end

                WAIT: begin
                    if (w_redirect) begin
                        r_pc_f <= w_target;
                        if (imem_rsp_valid) begin
                            // Stale response arrives together with the redirect: ignore it
                            r_drop      <= 1'b0;
                            r_state     <= FETCH;
                            r_req_valid <= 1'b1;
                        end else begin
                            r_drop      <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (r_drop) begin
                            r_drop      <= 1'b0;
                            r_state     <= FETCH;
                            r_req_valid <= 1'b1;
                        end else if (!r_valid_d || !stall_D) begin
                            r_instr_d   <= imem_rsp_data;
                            r_pc_d      <= r_fetch_addr;
                            r_valid_d   <= 1'b1;
                            r_state     <= FETCH;
                            r_req_valid <= 1'b1;
                        end else begin
                            // Payload goes into the skid buffer via w_skid_load
                            r_state     <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (w_redirect) begin
                        r_pc_f      <= w_target;
                        r_state     <= FETCH;
                        r_req_valid <= 1'b1;
                    end else if (!stall_D) begin
                        r_instr_d   <= w_skid_data;
                        r_pc_d      <= w_skid_addr;
                        r_valid_d   <= 1'b1;
                        r_state     <= FETCH;
                        r_req_valid <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= FETCH;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_addr      = r_pc_f;
    assign instr_D        = r_instr_d;
    assign pc_D           = r_pc_d;
    assign valid_D        = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small instruction memory model whose
// response latency is programmable; expected values are hand-derived.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall_D;
    logic        branch_taken_D;
    logic [31:0] branch_target_D;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic        valid_D;

    int          n_checks;
    int          n_fail;

    // memory model state
    int          mem_lat;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    int          n_acc;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .stall_D         (stall_D),
        .branch_taken_D  (branch_taken_D),
        .branch_target_D (branch_target_D),
        .instr_D         (instr_D),
        .pc_D            (pc_D),
        .valid_D         (valid_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction word stored at a given address
    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: note the handshake seen at the edge, then update the memory
    // model 1 time unit after the edge so the response is visible the next cycle.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid && imem_req_ready && rst;
        a   = imem_addr;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (acc) begin
            pend  = 1'b1;
            paddr = a;
            cnt   = mem_lat;
            n_acc++;
        end
        if (pend) begin
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word(paddr);
                pend           = 1'b0;
            end else begin
                cnt--;
            end
        end
    endtask

    initial begin
        int acc0;
        n_checks = 0;
        n_fail = 0;
        mem_lat = 0;
        pend = 1'b0;
        cnt = 0;
        paddr = '0;
        n_acc = 0;
        rst = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        stall_D = 1'b0;
        branch_taken_D = 1'b0;
        branch_target_D = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 0);
        check("rst_valid_d", 32'(valid_D), 0);
        check("rst_instr_d", instr_D, NOP);
        check("rst_pc_d", pc_D, 0);
        check("rst_addr", imem_addr, 0);

        // Streaming from reset with a zero-wait memory: one instruction per 2 cycles
        rst = 1'b1;
        step();
        check("first_req_valid", 32'(imem_req_valid), 1);
        check("first_req_addr", imem_addr, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stream_wait_req", 32'(imem_req_valid), 0);
            check("stream_bubble", 32'(valid_D), 0);
            step();
            check("stream_valid", 32'(valid_D), 1);
            check("stream_pc", pc_D, 32'(4 * k));
            check("stream_instr", instr_D, word(32'(4 * k)));
            check("stream_next_addr", imem_addr, 32'(4 * k + 4));
        end

        // Redirect to 0x103 while the request for 0xC is outstanding
        mem_lat = 3;
        stall_D = 1'b1;
        step();
        check("rd_hold_valid", 32'(valid_D), 1);
        check("rd_hold_pc", pc_D, 32'h8);
        stall_D = 1'b0;
        branch_taken_D = 1'b1;
        branch_target_D = 32'h103;
        step();
        branch_taken_D = 1'b0;
        check("rd_flush_valid", 32'(valid_D), 0);
        check("rd_flush_instr", instr_D, NOP);
        check("rd_wait_req", 32'(imem_req_valid), 0);
        step();
        check("rd_wait_req2", 32'(imem_req_valid), 0);
        step();
        check("rd_wait_req3", 32'(imem_req_valid), 0);
        step();
        check("rd_drop_valid", 32'(valid_D), 0);
        check("rd_drop_instr", instr_D, NOP);
        check("rd_new_req", 32'(imem_req_valid), 1);
        check("rd_new_addr", imem_addr, 32'h100);
        mem_lat = 0;

        // Back-pressure: ready low for 3 cycles keeps the request stable
        imem_req_ready = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_req_valid", 32'(imem_req_valid), 1);
            check("bp_req_addr", imem_addr, 32'h100);
        end
        imem_req_ready = 1'b1;
        step();
        check("bp_req_dropped", 32'(imem_req_valid), 0);
        check("bp_single_req", 32'(n_acc - acc0), 1);
        step();
        check("bp_valid", 32'(valid_D), 1);
        check("bp_pc", pc_D, 32'h100);
        check("bp_instr", instr_D, word(32'h100));

        // Decode stall for 4 cycles while the 0x104 response arrives
        stall_D = 1'b1;
        acc0 = n_acc;
        for (int i = 0; i < 4; i++) begin
            step();
            check("st_hold_valid", 32'(valid_D), 1);
            check("st_hold_pc", pc_D, 32'h100);
            check("st_hold_instr", instr_D, word(32'h100));
            check("st_no_req", 32'(imem_req_valid), 0);
        end
        check("st_one_req", 32'(n_acc - acc0), 1);
        stall_D = 1'b0;
        step();
        check("st_skid_valid", 32'(valid_D), 1);
        check("st_skid_pc", pc_D, 32'h104);
        check("st_skid_instr", instr_D, word(32'h104));
        check("st_next_addr", imem_addr, 32'h108);

        // Redirect coincident with the response for 0x108
        stall_D = 1'b1;
        step();
        stall_D = 1'b0;
        branch_taken_D = 1'b1;
        branch_target_D = 32'h200;
        step();
        branch_taken_D = 1'b0;
        check("co_flush_valid", 32'(valid_D), 0);
        check("co_flush_instr", instr_D, NOP);
        check("co_req_valid", 32'(imem_req_valid), 1);
        check("co_req_addr", imem_addr, 32'h200);
        step();
        step();
        check("co_nodrop_valid", 32'(valid_D), 1);
        check("co_nodrop_pc", pc_D, 32'h200);
        check("co_nodrop_instr", instr_D, word(32'h200));

        // Redirect in FETCH while the request is not accepted retargets it
        imem_req_ready = 1'b0;
        branch_taken_D = 1'b1;
        branch_target_D = 32'h300;
        step();
        branch_taken_D = 1'b0;
        imem_req_ready = 1'b1;
        check("fr_retarget", imem_addr, 32'h300);
        check("fr_req_valid", 32'(imem_req_valid), 1);
        check("fr_flush", 32'(valid_D), 0);
        step();
        step();
        check("fr_pc", pc_D, 32'h300);

        // Unaligned target near the top of the address space; pc_F wraps to 0
        imem_req_ready = 1'b0;
        branch_taken_D = 1'b1;
        branch_target_D = 32'hFFFF_FFFF;
        step();
        branch_taken_D = 1'b0;
        imem_req_ready = 1'b1;
        check("wr_aligned", imem_addr, 32'hFFFF_FFFC);
        step();
        step();
        check("wr_pc", pc_D, 32'hFFFF_FFFC);
        check("wr_instr", instr_D, word(32'hFFFF_FFFC));
        check("wr_next_addr", imem_addr, 32'h0);

        // Reset asserted in WAIT with a held instruction in IF/ID
        stall_D = 1'b1;
        step();
        check("ra_pre_valid", 32'(valid_D), 1);
        rst = 1'b0;
        #1;
        check("ra_valid", 32'(valid_D), 0);
        check("ra_instr", instr_D, NOP);
        check("ra_pc_d", pc_D, 0);
        check("ra_req_valid", 32'(imem_req_valid), 0);
        check("ra_addr", imem_addr, 0);
        stall_D = 1'b0;
        pend = 1'b0;
        imem_rsp_valid = 1'b0;
        step();
        check("ra_in_rst_req", 32'(imem_req_valid), 0);
        rst = 1'b1;
        step();
        check("ra_refetch_req", 32'(imem_req_valid), 1);
        check("ra_refetch_addr", imem_addr, 0);
        step();
        step();
        check("ra_refetch_valid", 32'(valid_D), 1);
        check("ra_refetch_pc", pc_D, 0);
        check("ra_refetch_instr", instr_D, word(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
